global_registers_access_master: RTL and testbench

- Initiator side of the global configuration register bus. It turns one queued command (read or write) into the single-cycle write/read strobe that the global register slave expects.
- For reads, it waits for the slave's one-cycle read-return beat and matches it against the issued address. It then presents the result, or a timeout, on a valid/ready response port.
- Sits between the configuration-packet parser and the global register slave inside the TSN NIC.

---
 rtl/global_registers_access_master.sv | 207 ++++++++++++++++++++
 tb/tb_global_registers_access_master.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/global_registers_access_master.sv
// Initiator for the global configuration register bus: turns one queued command into a
// single-cycle wr/rd strobe and returns read data (or a timeout) over a valid/ready port.
module global_registers_access_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_wr,
    input  logic [18:0] iv_cmd_addr,
    input  logic        i_cmd_addr_fixed,
    input  logic [31:0] iv_cmd_wdata,
    output logic        o_wr,
    output logic        o_rd,
    output logic [18:0] ov_addr,
    output logic        o_addr_fixed,
    output logic [31:0] ov_wdata,
    input  logic        i_rsp_wr,
    input  logic [18:0] iv_rsp_addr,
    input  logic        i_rsp_addr_fixed,
    input  logic [31:0] iv_rsp_rdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [18:0] ov_rsp_addr,
    output logic        o_rsp_addr_fixed,
    output logic [31:0] ov_rsp_rdata,
    output logic        o_rsp_timeout,
    output logic [15:0] ov_wr_cnt,
    output logic [15:0] ov_rd_cnt,
    output logic [15:0] ov_timeout_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RSP   = 2'd3;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [18:0] lat_addr_q, lat_addr_d;
    logic        lat_fixed_q, lat_fixed_d;

    logic        cmd_ready_q, cmd_ready_d;
    logic        wr_q, wr_d, rd_q, rd_d;
    logic [18:0] addr_q, addr_d;
    logic        fixed_q, fixed_d;
    logic [31:0] wdata_q, wdata_d;

    logic        rsp_valid_q, rsp_valid_d;
    logic [18:0] rsp_addr_q, rsp_addr_d;
    logic        rsp_fixed_q, rsp_fixed_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_timeout_q, rsp_timeout_d;

    logic [15:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, to_cnt_q, to_cnt_d;

    logic        rsp_match;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign rsp_match = i_rsp_wr && (iv_rsp_addr == lat_addr_q) && (i_rsp_addr_fixed == lat_fixed_q);

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        lat_addr_d    = lat_addr_q;
        lat_fixed_d   = lat_fixed_q;
        cmd_ready_d   = cmd_ready_q;
        // bus fields idle at zero unless a strobe is issued this cycle
        wr_d          = 1'b0;
        rd_d          = 1'b0;
        addr_d        = '0;
        fixed_d       = 1'b0;
        wdata_d       = '0;
        rsp_valid_d   = rsp_valid_q;
        rsp_addr_d    = rsp_addr_q;
        rsp_fixed_d   = rsp_fixed_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;
        wr_cnt_d      = wr_cnt_q;
        rd_cnt_d      = rd_cnt_q;
        to_cnt_d      = to_cnt_q;

        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_ready_q && i_cmd_valid) begin
                    cmd_ready_d = 1'b0;
                    state_d     = S_ISSUE;
                    wr_d        = i_cmd_wr;
                    rd_d        = !i_cmd_wr;
                    addr_d      = iv_cmd_addr;
                    fixed_d     = i_cmd_addr_fixed;
                    wdata_d     = i_cmd_wr ? iv_cmd_wdata : 32'd0;
                    lat_addr_d  = iv_cmd_addr;
                    lat_fixed_d = i_cmd_addr_fixed;
                end
            end
            S_ISSUE: begin
                if (wr_q) begin
                    state_d     = S_IDLE;
                    cmd_ready_d = 1'b1;
                    wr_cnt_d    = sat_inc(wr_cnt_q);
                end else begin
                    state_d    = S_WAIT;
                    wait_cnt_d = '0;
                end
            end
            S_WAIT: begin
                // a match on the final wait cycle still counts as data
                if (rsp_match) begin
                    state_d       = S_RSP;
                    rsp_valid_d   = 1'b1;
                    rsp_addr_d    = lat_addr_q;
                    rsp_fixed_d   = lat_fixed_q;
                    rsp_rdata_d   = iv_rsp_rdata;
                    rsp_timeout_d = 1'b0;
                    rd_cnt_d      = sat_inc(rd_cnt_q);
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d       = S_RSP;
                    rsp_valid_d   = 1'b1;
                    rsp_addr_d    = lat_addr_q;
                    rsp_fixed_d   = lat_fixed_q;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                    to_cnt_d      = sat_inc(to_cnt_q);
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                if (i_rsp_ready) begin
                    state_d       = S_IDLE;
                    cmd_ready_d   = 1'b1;
                    rsp_valid_d   = 1'b0;
                    rsp_addr_d    = '0;
                    rsp_fixed_d   = 1'b0;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= '0;
            lat_addr_q    <= '0;
            lat_fixed_q   <= 1'b0;
            cmd_ready_q   <= 1'b0;
            wr_q          <= 1'b0;
            rd_q          <= 1'b0;
            addr_q        <= '0;
            fixed_q       <= 1'b0;
            wdata_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_addr_q    <= '0;
            rsp_fixed_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            to_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            lat_addr_q    <= lat_addr_d;
            lat_fixed_q   <= lat_fixed_d;
            cmd_ready_q   <= cmd_ready_d;
            wr_q          <= wr_d;
            rd_q          <= rd_d;
            addr_q        <= addr_d;
            fixed_q       <= fixed_d;
            wdata_q       <= wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_addr_q    <= rsp_addr_d;
            rsp_fixed_q   <= rsp_fixed_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

    assign o_cmd_ready      = cmd_ready_q;
    assign o_wr             = wr_q;
    assign o_rd             = rd_q;
    assign ov_addr          = addr_q;
    assign o_addr_fixed     = fixed_q;
    assign ov_wdata         = wdata_q;
    assign o_rsp_valid      = rsp_valid_q;
    assign ov_rsp_addr      = rsp_addr_q;
    assign o_rsp_addr_fixed = rsp_fixed_q;
    assign ov_rsp_rdata     = rsp_rdata_q;
    assign o_rsp_timeout    = rsp_timeout_q;
    assign ov_wr_cnt        = wr_cnt_q;
    assign ov_rd_cnt        = rd_cnt_q;
    assign ov_timeout_cnt   = to_cnt_q;

endmodule

// File: tb/tb_global_registers_access_master.sv
// Bench for global_registers_access_master: directed scenarios plus randomized commands,
// checked against a transaction-level model of when and what the response should be.
module tb_global_registers_access_master;

    localparam int TO = 16;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_cmd_valid = 1'b0, o_cmd_ready, i_cmd_wr = 1'b0;
    logic [18:0] iv_cmd_addr = '0;
    logic        i_cmd_addr_fixed = 1'b0;
    logic [31:0] iv_cmd_wdata = '0;
    logic        o_wr, o_rd, o_addr_fixed;
    logic [18:0] ov_addr;
    logic [31:0] ov_wdata;
    logic        i_rsp_wr = 1'b0;
    logic [18:0] iv_rsp_addr = '0;
    logic        i_rsp_addr_fixed = 1'b0;
    logic [31:0] iv_rsp_rdata = '0;
    logic        o_rsp_valid, i_rsp_ready = 1'b0, o_rsp_addr_fixed, o_rsp_timeout;
    logic [18:0] ov_rsp_addr;
    logic [31:0] ov_rsp_rdata;
    logic [15:0] ov_wr_cnt, ov_rd_cnt, ov_timeout_cnt;

    global_registers_access_master #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_wr(i_cmd_wr),
        .iv_cmd_addr(iv_cmd_addr), .i_cmd_addr_fixed(i_cmd_addr_fixed), .iv_cmd_wdata(iv_cmd_wdata),
        .o_wr(o_wr), .o_rd(o_rd), .ov_addr(ov_addr), .o_addr_fixed(o_addr_fixed), .ov_wdata(ov_wdata),
        .i_rsp_wr(i_rsp_wr), .iv_rsp_addr(iv_rsp_addr), .i_rsp_addr_fixed(i_rsp_addr_fixed),
        .iv_rsp_rdata(iv_rsp_rdata), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .ov_rsp_addr(ov_rsp_addr), .o_rsp_addr_fixed(o_rsp_addr_fixed), .ov_rsp_rdata(ov_rsp_rdata),
        .o_rsp_timeout(o_rsp_timeout), .ov_wr_cnt(ov_wr_cnt), .ov_rd_cnt(ov_rd_cnt),
        .ov_timeout_cnt(ov_timeout_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          off;   // cycle offset from the first wait cycle (T+2)
        logic [18:0] addr;
        logic        fx;
        logic [31:0] data;
    } beat_t;

    beat_t bq[$];
    int total = 0, bad = 0;
    int exp_wr = 0, exp_rd = 0, exp_to = 0;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Waits (bounded) for ready, presents one command for the handshake cycle, returns at T+1.
    task automatic issue_cmd(input logic wr, input logic [18:0] a, input logic fx, input logic [31:0] d);
        int n = 0;
        while (!o_cmd_ready && n < 60) begin
            tick();
            n++;
        end
        total++;
        if (!o_cmd_ready) begin
            bad++;
            $display("FAIL cmd_ready_wait: o_cmd_ready=%0b after %0d cycles, required 1", o_cmd_ready, n);
        end
        i_cmd_valid = 1'b1; i_cmd_wr = wr; iv_cmd_addr = a; i_cmd_addr_fixed = fx; iv_cmd_wdata = d;
        tick();
        i_cmd_valid = 1'b0;
        iv_cmd_addr = 19'($urandom); i_cmd_addr_fixed = 1'($urandom); iv_cmd_wdata = $urandom;
        i_cmd_wr = 1'($urandom);
    endtask

    task automatic check_counters(input string tag);
        total++;
        if (ov_wr_cnt !== 16'(exp_wr) || ov_rd_cnt !== 16'(exp_rd) || ov_timeout_cnt !== 16'(exp_to)) begin
            bad++;
            $display("FAIL %s_counters: wr/rd/to=%0d/%0d/%0d required %0d/%0d/%0d", tag,
                     ov_wr_cnt, ov_rd_cnt, ov_timeout_cnt, exp_wr, exp_rd, exp_to);
        end
    endtask

    task automatic run_write(input logic [18:0] a, input logic fx, input logic [31:0] d);
        issue_cmd(1'b1, a, fx, d);
        total++;
        if ({o_wr, o_rd, ov_addr, o_addr_fixed, ov_wdata, o_cmd_ready} !== {1'b1, 1'b0, a, fx, d, 1'b0}) begin
            bad++;
            $display("FAIL wr_strobe: wr=%0b rd=%0b addr=%h fx=%0b wdata=%h rdy=%0b required 1 0 %h %0b %h 0",
                     o_wr, o_rd, ov_addr, o_addr_fixed, ov_wdata, o_cmd_ready, a, fx, d);
        end
        tick();
        exp_wr = (exp_wr == 65535) ? exp_wr : exp_wr + 1;
        total++;
        if ({o_wr, o_rd, ov_addr, o_addr_fixed, ov_wdata, o_cmd_ready} !== {1'b0, 1'b0, 19'd0, 1'b0, 32'd0, 1'b1}) begin
            bad++;
            $display("FAIL wr_idle: wr=%0b addr=%h fx=%0b wdata=%h rdy=%0b required 0 0 0 0 1",
                     o_wr, ov_addr, o_addr_fixed, ov_wdata, o_cmd_ready);
        end
        check_counters("wr");
    endtask

    // Beats to drive come from bq; the model picks the earliest matching beat inside the window.
    task automatic run_read(input logic [18:0] a, input logic fx, input int rdy_dly);
        int          resp_off = TO;
        logic [31:0] edata = '0;
        logic        eto = 1'b1;
        logic [31:0] held;
        foreach (bq[i])
            if (bq[i].off < TO && bq[i].addr == a && bq[i].fx == fx && (eto || bq[i].off + 1 < resp_off)) begin
                resp_off = bq[i].off + 1;
                edata    = bq[i].data;
                eto      = 1'b0;
            end
        issue_cmd(1'b0, a, fx, $urandom);
        total++;
        if ({o_rd, o_wr, ov_addr, o_addr_fixed, ov_wdata} !== {1'b1, 1'b0, a, fx, 32'd0}) begin
            bad++;
            $display("FAIL rd_strobe: rd=%0b wr=%0b addr=%h fx=%0b wdata=%h required 1 0 %h %0b 0",
                     o_rd, o_wr, ov_addr, o_addr_fixed, ov_wdata, a, fx);
        end
        for (int off = 0; off <= resp_off; off++) begin
            tick();
            if (off == 0) begin
                total++;
                if (o_rd !== 1'b0 || ov_addr !== 19'd0) begin
                    bad++;
                    $display("FAIL rd_idle: rd=%0b addr=%h required 0 0", o_rd, ov_addr);
                end
            end
            total++;
            if (o_rsp_valid !== (off == resp_off)) begin
                bad++;
                $display("FAIL rsp_timing: valid=%0b at wait offset %0d, required %0b", o_rsp_valid, off, off == resp_off);
            end
            i_rsp_wr = 1'b0; iv_rsp_addr = 19'($urandom); i_rsp_addr_fixed = 1'($urandom); iv_rsp_rdata = $urandom;
            foreach (bq[i])
                if (bq[i].off == off) begin
                    i_rsp_wr = 1'b1; iv_rsp_addr = bq[i].addr; i_rsp_addr_fixed = bq[i].fx; iv_rsp_rdata = bq[i].data;
                end
        end
        i_rsp_wr = 1'b0;
        if (eto) exp_to = (exp_to == 65535) ? exp_to : exp_to + 1;
        else     exp_rd = (exp_rd == 65535) ? exp_rd : exp_rd + 1;
        total++;
        if (ov_rsp_rdata !== edata || o_rsp_timeout !== eto || o_cmd_ready !== 1'b0 ||
            (!eto && (ov_rsp_addr !== a || o_rsp_addr_fixed !== fx))) begin
            bad++;
            $display("FAIL rsp_fields: rdata=%h to=%0b addr=%h fx=%0b rdy=%0b required %h %0b %h %0b 0",
                     ov_rsp_rdata, o_rsp_timeout, ov_rsp_addr, o_rsp_addr_fixed, o_cmd_ready, edata, eto, a, fx);
        end
        check_counters("rd");
        held = ov_rsp_rdata;
        for (int k = 0; k < rdy_dly; k++) begin
            tick();
            total++;
            if (o_rsp_valid !== 1'b1 || ov_rsp_rdata !== edata || o_rsp_timeout !== eto || o_cmd_ready !== 1'b0) begin
                bad++;
                $display("FAIL rsp_hold: valid=%0b rdata=%h(was %h) to=%0b rdy=%0b required 1 %h %0b 0",
                         o_rsp_valid, ov_rsp_rdata, held, o_rsp_timeout, o_cmd_ready, edata, eto);
            end
        end
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        total++;
        if ({o_rsp_valid, ov_rsp_rdata, o_rsp_timeout, ov_rsp_addr, o_rsp_addr_fixed, o_cmd_ready} !==
            {1'b0, 32'd0, 1'b0, 19'd0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL rsp_clear: valid=%0b rdata=%h to=%0b addr=%h rdy=%0b required 0 0 0 0 1",
                     o_rsp_valid, ov_rsp_rdata, o_rsp_timeout, ov_rsp_addr, o_cmd_ready);
        end
    endtask

    task automatic check_all_zero(input string tag);
        total++;
        if ({o_cmd_ready, o_wr, o_rd, ov_addr, o_addr_fixed, ov_wdata, o_rsp_valid, ov_rsp_addr,
             o_rsp_addr_fixed, ov_rsp_rdata, o_rsp_timeout, ov_wr_cnt, ov_rd_cnt, ov_timeout_cnt} !== '0) begin
            bad++;
            $display("FAIL %s_zero: rdy=%0b wr=%0b rd=%0b addr=%h valid=%0b rdata=%h cnts=%0d/%0d/%0d required all 0",
                     tag, o_cmd_ready, o_wr, o_rd, ov_addr, o_rsp_valid, ov_rsp_rdata,
                     ov_wr_cnt, ov_rd_cnt, ov_timeout_cnt);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick(); tick();
        check_all_zero("reset");
        i_rst = 1'b0;
        tick();
        total++;
        if (o_cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: o_cmd_ready=%0b required 1", o_cmd_ready);
        end
    endtask

    task automatic test_write();
        run_write(19'd4, 1'b1, 32'h0000_001F);
        run_write(19'h7FFFF, 1'b0, 32'hDEAD_BEEF);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) run_write(19'($urandom), 1'($urandom), $urandom);
    endtask

    task automatic test_read();
        bq.delete();
        bq.push_back('{0, 19'd3, 1'b1, 32'h1});
        run_read(19'd3, 1'b1, 0);
    endtask

    task automatic test_timeout();
        bq.delete();
        run_read(19'd5, 1'b1, 0);
    endtask

    task automatic test_ignore_beat();
        bq.delete();
        bq.push_back('{0, 19'd1, 1'b1, 32'h99});
        bq.push_back('{1, 19'd2, 1'b0, 32'h77});
        bq.push_back('{2, 19'd2, 1'b1, 32'h40});
        run_read(19'd2, 1'b1, 0);
        bq.delete();
        bq.push_back('{TO - 1, 19'd9, 1'b0, 32'hCAFE_0001});
        run_read(19'd9, 1'b0, 1);
    endtask

    task automatic test_backpressure();
        bq.delete();
        bq.push_back('{1, 19'd6, 1'b0, 32'h1234_5678});
        run_read(19'd6, 1'b0, 5);
    endtask

    task automatic test_reset_mid();
        logic [18:0] a = 19'd7;
        issue_cmd(1'b0, a, 1'b1, 32'd0);
        tick(); tick(); tick();
        i_rst = 1'b1;
        tick();
        check_all_zero("midrst");
        i_rst = 1'b0;
        i_rsp_wr = 1'b1; iv_rsp_addr = a; i_rsp_addr_fixed = 1'b1; iv_rsp_rdata = 32'h55;
        tick();
        exp_wr = 0; exp_rd = 0; exp_to = 0;
        total++;
        if (o_cmd_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_release: rdy=%0b valid=%0b required 1 0", o_cmd_ready, o_rsp_valid);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (o_rsp_valid !== 1'b0 || o_rd !== 1'b0 || o_wr !== 1'b0) begin
                bad++;
                $display("FAIL midrst_quiet: valid=%0b rd=%0b wr=%0b required 0 0 0", o_rsp_valid, o_rd, o_wr);
            end
        end
        i_rsp_wr = 1'b0;
        check_counters("midrst");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [18:0] a = 19'($urandom_range(0, 15));
            logic        fx = 1'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                run_write(a, fx, $urandom);
            end else begin
                bq.delete();
                if ($urandom_range(0, 1) == 1)
                    bq.push_back('{int'($urandom_range(0, TO - 1)), a ^ 19'd1, fx, $urandom});
                if ($urandom_range(0, 2) == 0)
                    bq.push_back('{int'($urandom_range(0, TO - 1)), a, ~fx, $urandom});
                if ($urandom_range(0, 3) != 0)
                    bq.push_back('{int'($urandom_range(0, TO + 2)), a, fx, $urandom});
                run_read(a, fx, int'($urandom_range(0, 3)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_back_to_back();
        test_read();
        test_timeout();
        test_ignore_beat();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
